// File: rtl/banked_rf_pkg.sv
// Shared types and helpers for banked_reg_file.
// Provides the clear-engine state type and the derived-size helpers.
// phys_idx is the single logical-to-physical mapping used by the read, write and clear paths.
package banked_rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Number of banked entries per bank.
  function automatic int calc_bsz(input int aw, input int nglobal);
    return (1 << aw) - nglobal;
  endfunction

  // Total physical depth: globals plus every bank.
  function automatic int calc_depth(input int aw, input int nglobal, input int nbank);
    return nglobal + nbank * calc_bsz(aw, nglobal);
  endfunction

  // Index width for n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Globals map straight through; banked addresses land in the bank's slice.
  function automatic int phys_idx(input int addr, input int bank,
                                  input int nglobal, input int bsz);
    if (addr < nglobal) return addr;
    return nglobal + bank * bsz + (addr - nglobal);
  endfunction

endpackage

// File: rtl/rf_clear_fsm.sv
// Bank-clear engine: walks one bank entry per cycle, then pulses done.
// Ports: clr_req/clr_bank start a clear; clr_we/clr_idx drive the zero write;
//        clr_busy covers CLEAR and DONE; clr_done pulses for one cycle.
module rf_clear_fsm
  import banked_rf_pkg::*;
#(
  parameter int NGLOBAL = 2,
  parameter int NBANK   = 3,
  parameter int BSZ     = 6,
  parameter int BW      = 2,
  parameter int CW      = 3,
  parameter int PIW     = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clr_req,
  input  logic [BW-1:0]  clr_bank,
  output logic           clr_we,
  output logic [PIW-1:0] clr_idx,
  output logic           clr_busy,
  output logic           clr_done
);

  clr_state_t    state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] lbank;

  // Counter offset is treated as a logical address just past the globals.
  assign clr_idx = PIW'(phys_idx(NGLOBAL + int'(cnt), int'(lbank), NGLOBAL, BSZ));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lbank    <= '0;
      clr_we   <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Out-of-range banks are dropped silently.
          if (clr_req && (int'(clr_bank) < NBANK)) begin
            lbank    <= clr_bank;
            cnt      <= '0;
            state    <= CLEAR;
            clr_we   <= 1'b1;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == CW'(BSZ - 1)) begin
            cnt      <= '0;
            state    <= DONE;
            clr_we   <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_we   <= 1'b0;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/banked_reg_file.sv
// Banked register file: 2^AW logical window over NGLOBAL shared + NBANK*BSZ banked entries.
// Ports: write_en/waddr/data_in write port; raddrA/raddrB combinational reads; accum = physical 0;
//        bank = active bank; clr_req/clr_bank/clr_busy/clr_done drive the bank-clear engine.
// Optional macro BANKED_RF_BYPASS_EN: same-cycle write/clear data is forwarded to the read ports.
module banked_reg_file
  import banked_rf_pkg::*;
#(
  parameter int W        = 8,
  parameter int AW       = 3,
  parameter int NGLOBAL  = 2,
  parameter int NBANK    = 3,
  parameter int BSEL_REG = 1,
  localparam int BW      = idx_width(NBANK)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          write_en,
  input  logic [AW-1:0] raddrA,
  input  logic [AW-1:0] raddrB,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  data_in,
  output logic [W-1:0]  data_outA,
  output logic [W-1:0]  data_outB,
  output logic [W-1:0]  accum,
  output logic [BW-1:0] bank,
  input  logic          clr_req,
  input  logic [BW-1:0] clr_bank,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam int BSZ   = calc_bsz(AW, NGLOBAL);
  localparam int DEPTH = calc_depth(AW, NGLOBAL, NBANK);
  localparam int CW    = idx_width(BSZ);
  localparam int PIW   = idx_width(DEPTH);

  logic [W-1:0]   rf [DEPTH];
  logic [W-1:0]   bsel_val;
  logic [BW-1:0]  cur_bank;
  logic [PIW-1:0] ridx_a, ridx_b, widx, clr_idx;
  logic           clr_we;

  // A select value outside the bank range falls back to bank 0.
  assign bsel_val = rf[BSEL_REG];
  always_comb begin
    cur_bank = '0;
    if (int'(bsel_val) < NBANK) cur_bank = bsel_val[BW-1:0];
  end
  assign bank = cur_bank;

  assign ridx_a = PIW'(phys_idx(int'(raddrA), int'(cur_bank), NGLOBAL, BSZ));
  assign ridx_b = PIW'(phys_idx(int'(raddrB), int'(cur_bank), NGLOBAL, BSZ));
  assign widx   = PIW'(phys_idx(int'(waddr),  int'(cur_bank), NGLOBAL, BSZ));

  rf_clear_fsm #(
    .NGLOBAL (NGLOBAL),
    .NBANK   (NBANK),
    .BSZ     (BSZ),
    .BW      (BW),
    .CW      (CW),
    .PIW     (PIW)
  ) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .clr_bank (clr_bank),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // Port write is ordered after the clear so it wins on a shared index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      if (clr_we)   rf[clr_idx] <= '0;
      if (write_en) rf[widx]    <= data_in;
    end
  end

`ifdef BANKED_RF_BYPASS_EN
  assign data_outA = (write_en && ridx_a == widx)    ? data_in :
                     (clr_we   && ridx_a == clr_idx) ? '0      : rf[ridx_a];
  assign data_outB = (write_en && ridx_b == widx)    ? data_in :
                     (clr_we   && ridx_b == clr_idx) ? '0      : rf[ridx_b];
`else
  assign data_outA = rf[ridx_a];
  assign data_outB = rf[ridx_b];
`endif

  assign accum = rf[0];

endmodule

// File: tb/tb_banked_reg_file.sv
module tb_banked_reg_file;

  localparam int NG    = 2;
  localparam int NB    = 3;
  localparam int BSZ   = 6;
  localparam int DEPTH = 20;

  logic       clk = 1'b0;
  logic       reset, write_en, clr_req;
  logic [2:0] raddrA, raddrB, waddr;
  logic [7:0] data_in;
  logic [1:0] clr_bank;
  logic [7:0] data_outA, data_outB, accum;
  logic [1:0] bank;
  logic       clr_busy, clr_done;

  always #5 clk = ~clk;

  banked_reg_file dut (
    .clk       (clk),
    .reset     (reset),
    .write_en  (write_en),
    .raddrA    (raddrA),
    .raddrB    (raddrB),
    .waddr     (waddr),
    .data_in   (data_in),
    .data_outA (data_outA),
    .data_outB (data_outB),
    .accum     (accum),
    .bank      (bank),
    .clr_req   (clr_req),
    .clr_bank  (clr_bank),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int busy_seen, done_seen;

  // Reference model: flat array plus "cycles left" of the clear operation.
  logic [7:0] mem [DEPTH];
  int left = 0;   // 0 idle; BSZ+1..2 clearing; 1 done cycle
  int cb   = 0;

  function automatic int m_bank();
    int v;
    v = int'(mem[1]);
    return (v < NB) ? v : 0;
  endfunction

  function automatic int m_phys(input int a);
    return (a < NG) ? a : NG + m_bank() * BSZ + (a - NG);
  endfunction

  function automatic int m_clr_tgt();
    return (left >= 2) ? NG + cb * BSZ + (BSZ + 1 - left) : -1;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    int idx;
    idx = m_phys(a);
`ifdef BANKED_RF_BYPASS_EN
    if (write_en && m_phys(int'(waddr)) == idx) return data_in;
    if (idx == m_clr_tgt()) return 8'h00;
`endif
    return mem[idx];
  endfunction

  task automatic model_edge();
    int widx, tgt;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      left = 0;
    end else begin
      widx = m_phys(int'(waddr));
      tgt  = m_clr_tgt();
      if (left > 0) left--;
      else if (clr_req && int'(clr_bank) < NB) begin
        left = BSZ + 1;
        cb   = int'(clr_bank);
      end
      if (tgt >= 0) mem[tgt] = 8'h00;
      if (write_en) mem[widx] = data_in;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are set at the falling edge; compare just after, then clock once.
  task automatic tick();
    #1;
    if (chk_en) begin
      chk("rdA",   data_outA, m_read(int'(raddrA)));
      chk("rdB",   data_outB, m_read(int'(raddrB)));
      chk("accum", accum,     mem[0]);
      chk("bank",  bank,      m_bank());
      chk("busy",  clr_busy,  left > 0);
      chk("done",  clr_done,  left == 1);
    end
    busy_seen += int'(clr_busy);
    done_seen += int'(clr_done);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    write_en = 1'b1; waddr = a; data_in = d;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [7:0] exp);
    raddrA = a;
    #1;
    chk(name, data_outA, exp);
    tick();
  endtask

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
    logic [1:0] ebank;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 3'd3, 8'h11, 3'd0, 3'd1, 8'h00, 8'h00, 2'd0};
    tbl[1]  = '{1'b1, 3'd1, 8'h01, 3'd3, 3'd2, 8'h11, 8'h00, 2'd0};
    tbl[2]  = '{1'b1, 3'd3, 8'h22, 3'd1, 3'd0, 8'h01, 8'h00, 2'd1};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd1, 8'h22, 8'h01, 2'd1};
    tbl[4]  = '{1'b1, 3'd1, 8'h00, 3'd3, 3'd0, 8'h22, 8'h00, 2'd1};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd1, 8'h11, 8'h00, 2'd0};
    tbl[6]  = '{1'b1, 3'd0, 8'h77, 3'd2, 3'd1, 8'h00, 8'h00, 2'd0};
    tbl[7]  = '{1'b1, 3'd1, 8'h01, 3'd0, 3'd3, 8'h77, 8'h11, 2'd0};
    tbl[8]  = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd3, 8'h77, 8'h22, 2'd1};
    tbl[9]  = '{1'b1, 3'd1, 8'h05, 3'd4, 3'd3, 8'h00, 8'h22, 2'd1};
    tbl[10] = '{1'b1, 3'd4, 8'h99, 3'd3, 3'd1, 8'h11, 8'h05, 2'd0};
    tbl[11] = '{1'b0, 3'd0, 8'h00, 3'd4, 3'd7, 8'h99, 8'h00, 2'd0};
    tbl[12] = '{1'b1, 3'd1, 8'h00, 3'd4, 3'd0, 8'h99, 8'h77, 2'd0};

    reset = 1'b1; write_en = 1'b0; clr_req = 1'b0; clr_bank = '0;
    raddrA = '0; raddrB = '0; waddr = '0; data_in = '0;
    busy_seen = 0; done_seen = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    for (int a = 0; a < 8; a++) begin
      raddrA = 3'(a); raddrB = 3'(7 - a);
      #1;
      chk("rst_rdA", data_outA, 8'h00);
      chk("rst_rdB", data_outB, 8'h00);
      tick();
    end
    chk("rst_bank",  bank,     2'd0);
    chk("rst_accum", accum,    8'h00);
    chk("rst_busy",  clr_busy, 1'b0);

    // Bank switching and out-of-range select
    for (int i = 0; i < 13; i++) begin
      write_en = tbl[i].we; waddr = tbl[i].wa; data_in = tbl[i].wd;
      raddrA = tbl[i].ra; raddrB = tbl[i].rb;
      #1;
      chk("tbl_rdA",  data_outA, tbl[i].ea);
      chk("tbl_rdB",  data_outB, tbl[i].eb);
      chk("tbl_bank", bank,      tbl[i].ebank);
      tick();
    end
    write_en = 1'b0;

    // Fill bank 2, return to bank 0, clear bank 2
    wr(3'd1, 8'h02);
    for (int a = 2; a < 8; a++) wr(3'(a), 8'hAA);
    wr(3'd1, 8'h00);
    clr_req = 1'b1; clr_bank = 2'd2;
    tick();
    clr_req = 1'b0;
    busy_seen = 0; done_seen = 0;
    repeat (12) tick();
    chk("clr_busy_cycles", busy_seen, 7);
    chk("clr_done_pulses", done_seen, 1);
    rd_chk("clr_keep_b0", 3'd3, 8'h11);
    wr(3'd1, 8'h01);
    rd_chk("clr_keep_b1", 3'd3, 8'h22);
    wr(3'd1, 8'h02);
    for (int a = 2; a < 8; a++) rd_chk("clr_zero_b2", 3'(a), 8'h00);

    // Clear with a port write to the entry being cleared (logical 5 = offset 3)
    for (int a = 2; a < 8; a++) wr(3'(a), 8'hAA);
    clr_req = 1'b1; clr_bank = 2'd2;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    wr(3'd5, 8'h55);
    repeat (10) tick();
    rd_chk("coll_win",  3'd5, 8'h55);
    rd_chk("coll_clr4", 3'd4, 8'h00);
    rd_chk("coll_clr6", 3'd6, 8'h00);

    // Reset in the third CLEAR cycle
    wr(3'd2, 8'hAA);
    wr(3'd0, 8'h5A);
    clr_req = 1'b1; clr_bank = 2'd2;
    tick();
    clr_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    busy_seen = 0; done_seen = 0;
    repeat (10) tick();
    chk("rstclr_no_done", done_seen, 0);
    chk("rstclr_bank",    bank,      2'd0);
    chk("rstclr_accum",   accum,     8'h00);
    for (int a = 0; a < 8; a++) rd_chk("rstclr_zero", 3'(a), 8'h00);

    // Fresh clear after reset; second request while busy is dropped
    clr_req = 1'b1; clr_bank = 2'd1;
    tick();
    busy_seen = 0; done_seen = 0;
    clr_bank = 2'd0;
    tick();
    clr_req = 1'b0;
    repeat (12) tick();
    chk("busy_ign_cycles", busy_seen, 7);
    chk("busy_ign_done",   done_seen, 1);

    // Same-cycle write and read of one entry
    wr(3'd1, 8'h00);
    wr(3'd5, 8'h12);
    write_en = 1'b1; waddr = 3'd5; data_in = 8'h3C; raddrA = 3'd5;
    #1;
`ifdef BANKED_RF_BYPASS_EN
    chk("bypass_rd", data_outA, 8'h3C);
`else
    chk("bypass_rd", data_outA, 8'h12);
`endif
    tick();
    write_en = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset    = ($urandom_range(0, 99) == 0);
      clr_req  = ($urandom_range(0, 7) == 0);
      clr_bank = 2'($urandom_range(0, 3));
      write_en = 1'($urandom_range(0, 1));
      waddr    = 3'($urandom_range(0, 7));
      data_in  = 8'($urandom);
      if (waddr == 3'd1 && $urandom_range(0, 3) != 0) data_in = 8'($urandom_range(0, 5));
      raddrA   = 3'($urandom_range(0, 7));
      raddrB   = 3'($urandom_range(0, 7));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_reg_file.md
Name: banked_reg_file

Overview:
- Parametrised successor of the 8-entry windowed register file.
- A small logical address window (2^AW entries) maps onto a larger physical array. The low NGLOBAL entries are shared by all banks; the remaining entries are banked.
- The bank is selected by the contents of a designated global register.
- Adds a multi-cycle bank-clear engine with a busy/done handshake. Sits between decode and the ALU/writeback stage of the core.

Parameters:
W, 8, data width of every register
AW, 3, logical register address width (window size 2^AW)
NGLOBAL, 2, number of unbanked global registers (logical 0..NGLOBAL-1)
NBANK, 3, number of banks
BSEL_REG, 1, global register whose value selects the active bank (must be < NGLOBAL)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
write_en  input  1  write strobe for waddr/data_in
raddrA  input  AW  logical read address A
raddrB  input  AW  logical read address B
waddr  input  AW  logical write address
data_in  input  W  write data
data_outA  output  W  read data A (combinational)
data_outB  output  W  read data B (combinational)
accum  output  W  always physical register 0
bank  output  clog2(NBANK)  active bank currently used for mapping
clr_req  input  1  one-cycle request to zero a bank
clr_bank  input  clog2(NBANK)  bank to clear, sampled with clr_req
clr_busy  output  1  clear engine active
clr_done  output  1  one-cycle pulse when a clear completes

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Array sizing:
  - BSZ = 2^AW - NGLOBAL.
  - Physical depth = NGLOBAL + NBANK*BSZ; default is 20 entries.
- Address mapping, logical address a:
  - a < NGLOBAL → physical a.
  - Otherwise → NGLOBAL + b*BSZ + (a - NGLOBAL).
  - b = reg[BSEL_REG] when that value is < NBANK; otherwise b = 0.
  - The bank output equals b.
- Reads: combinational, zero latency, both ports independent.
  - Same-cycle write to the read address returns the old value (see the optional feature).
- Writes:
  - On a clk edge with write_en=1, physical(waddr) <= data_in.
  - Mapping uses the bank in effect during that cycle.
  - Writing BSEL_REG changes the mapping from the next cycle onward.
- Clear engine FSM has three states: IDLE, CLEAR, DONE.
  - IDLE: on clr_req=1 with clr_bank < NBANK, latch clr_bank, set counter=0, go to CLEAR.
  - IDLE: clr_req with clr_bank >= NBANK is ignored.
  - CLEAR: each cycle zero physical NGLOBAL + clr_bank*BSZ + counter and increment counter. After counter = BSZ-1 is cleared, go to DONE. A clear therefore lasts exactly BSZ cycles.
  - DONE: clr_done=1 for one cycle, then IDLE.
  - clr_busy=1 in CLEAR and DONE. clr_req while busy is ignored, not queued.
  - Global registers are never touched by the clear engine.
- Collision: if a port write and the clear target hit the same physical entry in the same cycle, the port write wins. Port writes are never stalled or dropped.
- Reset:
  - Effects: every physical register = 0, FSM = IDLE, counter = 0.
  - Resulting outputs: data_outA/B = 0, accum = 0, bank = 0, clr_busy = 0, clr_done = 0.
  - Reset during CLEAR aborts the clear with no clr_done pulse.
  - Reset has priority over write_en and clr_req.
- Arithmetic: counter width is clog2(BSZ). Physical index width is clog2(physical depth), computed without truncation.

Optional Feature:
- Macro: BANKED_RF_BYPASS_EN.
- Defined: a read whose physical index equals the physical write index while write_en=1 returns data_in in the same cycle.
  - A read of an entry being cleared that cycle, with no port write to it, returns 0.
- Undefined: reads always return the stored (pre-edge) value.

Decomposition:
- Package banked_rf_pkg holds:
  - FSM state enum {IDLE, CLEAR, DONE}.
  - Derived-constant helpers (BSZ, depth, index widths).
  - Function phys_idx(addr, bank), shared by the read, write and clear paths.
- One sub-module, rf_clear_fsm, contains the state, counter and latched bank. It outputs clr_we, clr_idx, clr_busy and clr_done.
- The top-level block owns the array, mapping and write arbitration.

Test Plan:
1. Reset, then read all 8 logical addresses → all 0; bank=0; accum=0; clr_busy=0.
2. Bank switching:
   - Write 0x11 to logical 3 in bank 0. Write reg1=1. Write 0x22 to logical 3 → read logical 3 = 0x22.
   - Write reg1=0 → logical 3 reads 0x11.
   - Logical 0 and 1 read identically in both banks.
3. Write reg1=5 (out of range) → bank=0; logical 4 accesses bank-0 storage.
4. Clear with collision:
   - Fill bank 2 with 0xAA. Pulse clr_req with clr_bank=2 → clr_busy is high for 6 CLEAR cycles plus 1 DONE cycle; clr_done pulses once; bank 2 entries read 0; banks 0/1 are unchanged.
   - In a repeat run, write 0x55 to the entry being cleared in the same cycle → 0x55 survives.
5. Reset during CLEAR:
   - Assert reset in cycle 3 of CLEAR → no clr_done; all registers 0; a following clr_req starts a full clear normally.
   - clr_req while busy is ignored.
6. With BANKED_RF_BYPASS_EN defined: write 0x3C to logical 5 and read logical 5 in the same cycle → data_outA=0x3C. Without the macro → previous value.
